// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register: captures decoded control, operands and register indices,
// squashes on flush/bubble, holds on freeze, and keeps saturating bubble/flush counters.
module id_exe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CMD_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              bubble,
    input  logic              id_valid,
    input  logic              id_wb_en,
    input  logic              id_mem_r,
    input  logic              id_mem_w,
    input  logic              id_branch,
    input  logic              id_imm_sel,
    input  logic [CMD_W-1:0]  id_exe_cmd,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_val1,
    input  logic [DATA_W-1:0] id_val2,
    input  logic [DATA_W-1:0] id_st_val,
    input  logic [REG_W-1:0]  id_dest,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    output logic              exe_valid,
    output logic              exe_wb_en,
    output logic              exe_mem_r,
    output logic              exe_mem_w,
    output logic              exe_branch,
    output logic              exe_imm_sel,
    output logic [CMD_W-1:0]  exe_exe_cmd,
    output logic [DATA_W-1:0] exe_pc,
    output logic [DATA_W-1:0] exe_val1,
    output logic [DATA_W-1:0] exe_val2,
    output logic [DATA_W-1:0] exe_st_val,
    output logic [REG_W-1:0]  exe_dest,
    output logic [REG_W-1:0]  exe_src1,
    output logic [REG_W-1:0]  exe_src2,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              r_valid;
    logic              r_wb_en;
    logic              r_mem_r;
    logic              r_mem_w;
    logic              r_branch;
    logic              r_imm_sel;
    logic [CMD_W-1:0]  r_exe_cmd;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_val1;
    logic [DATA_W-1:0] r_val2;
    logic [DATA_W-1:0] r_st_val;
    logic [REG_W-1:0]  r_dest;
    logic [REG_W-1:0]  r_src1;
    logic [REG_W-1:0]  r_src2;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_update;
    logic              w_squash;
    logic              w_do_bubble;
    logic              w_wb_en;
    logic              w_mem_r;
    logic              w_mem_w;
    logic              w_branch;
    logic              w_imm_sel;
    logic [CMD_W-1:0]  w_exe_cmd;
    logic [REG_W-1:0]  w_dest;
    logic [REG_W-1:0]  w_src1;
    logic [REG_W-1:0]  w_src2;
    logic              w_bubble_sat;
    logic              w_flush_sat;

    // flush beats freeze so a squash is never lost while memory stalls
    assign w_update    = flush | ~freeze;
    assign w_do_bubble = bubble & ~flush & ~freeze;
    assign w_squash    = flush | w_do_bubble;

    // an invalid ID slot must look like r0 to forwarding, same as a squash
    always_comb begin
        w_wb_en   = 1'b0;
        w_mem_r   = 1'b0;
        w_mem_w   = 1'b0;
        w_branch  = 1'b0;
        w_imm_sel = 1'b0;
        w_exe_cmd = '0;
        w_dest    = '0;
        w_src1    = '0;
        w_src2    = '0;
        if (id_valid) begin
            w_wb_en   = id_wb_en;
            w_mem_r   = id_mem_r;
            w_mem_w   = id_mem_w;
            w_branch  = id_branch;
            w_imm_sel = id_imm_sel;
            w_exe_cmd = id_exe_cmd;
            w_dest    = id_dest;
            w_src1    = id_src1;
            w_src2    = id_src2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_wb_en   <= 1'b0;
            r_mem_r   <= 1'b0;
            r_mem_w   <= 1'b0;
            r_branch  <= 1'b0;
            r_imm_sel <= 1'b0;
            r_exe_cmd <= '0;
            r_pc      <= '0;
            r_val1    <= '0;
            r_val2    <= '0;
            r_st_val  <= '0;
            r_dest    <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
        end else if (w_update) begin
            if (w_squash) begin
                r_valid   <= 1'b0;
                r_wb_en   <= 1'b0;
                r_mem_r   <= 1'b0;
                r_mem_w   <= 1'b0;
                r_branch  <= 1'b0;
                r_imm_sel <= 1'b0;
                r_exe_cmd <= '0;
                r_pc      <= '0;
                r_val1    <= '0;
                r_val2    <= '0;
                r_st_val  <= '0;
                r_dest    <= '0;
                r_src1    <= '0;
                r_src2    <= '0;
            end else begin
                r_valid   <= id_valid;
                r_wb_en   <= w_wb_en;
                r_mem_r   <= w_mem_r;
                r_mem_w   <= w_mem_w;
                r_branch  <= w_branch;
                r_imm_sel <= w_imm_sel;
                r_exe_cmd <= w_exe_cmd;
                r_pc      <= id_pc;
                r_val1    <= id_val1;
                r_val2    <= id_val2;
                r_st_val  <= id_st_val;
                r_dest    <= w_dest;
                r_src1    <= w_src1;
                r_src2    <= w_src2;
            end
        end
    end

    assign w_bubble_sat = &r_bubble_cnt;
    assign w_flush_sat  = &r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (flush && !w_flush_sat)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if (w_do_bubble && !w_bubble_sat)
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign exe_valid   = r_valid;
    assign exe_wb_en   = r_wb_en;
    assign exe_mem_r   = r_mem_r;
    assign exe_mem_w   = r_mem_w;
    assign exe_branch  = r_branch;
    assign exe_imm_sel = r_imm_sel;
    assign exe_exe_cmd = r_exe_cmd;
    assign exe_pc      = r_pc;
    assign exe_val1    = r_val1;
    assign exe_val2    = r_val2;
    assign exe_st_val  = r_st_val;
    assign exe_dest    = r_dest;
    assign exe_src1    = r_src1;
    assign exe_src2    = r_src2;
    assign bubble_cnt  = r_bubble_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Scoreboard bench for id_exe_stage_reg: directed vectors push expected EXE state,
// a monitor pops and compares after every clock edge or reset assertion.
module tb_id_exe_stage_reg;

    typedef struct packed {
        logic        valid, wb, mr, mw, br, imm;
        logic [3:0]  cmd;
        logic [31:0] pc, v1, v2, st;
        logic [4:0]  dest, s1, s2;
    } in_t;

    typedef struct packed {
        in_t         o;
        logic [15:0] bc, fc;
        logic [3:0]  bc4, fc4;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic freeze = 1'b0, flush = 1'b0, bubble = 1'b0;
    in_t  id = '0;

    logic        e_valid, e_wb, e_mr, e_mw, e_br, e_imm;
    logic [3:0]  e_cmd;
    logic [31:0] e_pc, e_v1, e_v2, e_st;
    logic [4:0]  e_dest, e_s1, e_s2;
    logic [15:0] bcnt, fcnt;

    logic        s_valid, s_wb, s_mr, s_mw, s_br, s_imm;
    logic [3:0]  s_cmd;
    logic [31:0] s_pc, s_v1, s_v2, s_st;
    logic [4:0]  s_dest, s_s1, s_s2;
    logic [3:0]  bcnt4, fcnt4;

    always #5 clk = ~clk;

    id_exe_stage_reg #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .bubble(bubble),
        .id_valid(id.valid), .id_wb_en(id.wb), .id_mem_r(id.mr), .id_mem_w(id.mw),
        .id_branch(id.br), .id_imm_sel(id.imm), .id_exe_cmd(id.cmd), .id_pc(id.pc),
        .id_val1(id.v1), .id_val2(id.v2), .id_st_val(id.st), .id_dest(id.dest),
        .id_src1(id.s1), .id_src2(id.s2),
        .exe_valid(e_valid), .exe_wb_en(e_wb), .exe_mem_r(e_mr), .exe_mem_w(e_mw),
        .exe_branch(e_br), .exe_imm_sel(e_imm), .exe_exe_cmd(e_cmd), .exe_pc(e_pc),
        .exe_val1(e_v1), .exe_val2(e_v2), .exe_st_val(e_st), .exe_dest(e_dest),
        .exe_src1(e_s1), .exe_src2(e_s2), .bubble_cnt(bcnt), .flush_cnt(fcnt)
    );

    id_exe_stage_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .bubble(bubble),
        .id_valid(id.valid), .id_wb_en(id.wb), .id_mem_r(id.mr), .id_mem_w(id.mw),
        .id_branch(id.br), .id_imm_sel(id.imm), .id_exe_cmd(id.cmd), .id_pc(id.pc),
        .id_val1(id.v1), .id_val2(id.v2), .id_st_val(id.st), .id_dest(id.dest),
        .id_src1(id.s1), .id_src2(id.s2),
        .exe_valid(s_valid), .exe_wb_en(s_wb), .exe_mem_r(s_mr), .exe_mem_w(s_mw),
        .exe_branch(s_br), .exe_imm_sel(s_imm), .exe_exe_cmd(s_cmd), .exe_pc(s_pc),
        .exe_val1(s_v1), .exe_val2(s_v2), .exe_st_val(s_st), .exe_dest(s_dest),
        .exe_src1(s_s1), .exe_src2(s_s2), .bubble_cnt(bcnt4), .flush_cnt(fcnt4)
    );

    exp_t  q_exp[$];
    string q_name[$];
    int    n_cmp = 0;
    int    n_err = 0;
    exp_t  cur;

    // Hand-written vectors
    localparam in_t V1 = '{valid:1'b1, wb:1'b1, mr:1'b0, mw:1'b0, br:1'b0, imm:1'b1,
                           cmd:4'h3, pc:32'h0000_0104, v1:32'hDEAD_BEEF,
                           v2:32'h0000_0011, st:32'h0000_0022, dest:5'd5, s1:5'd3, s2:5'd2};
    localparam in_t V2 = '{valid:1'b1, wb:1'b1, mr:1'b1, mw:1'b0, br:1'b0, imm:1'b1,
                           cmd:4'h9, pc:32'h0000_0200, v1:32'h1234_5678,
                           v2:32'hFFFF_FFF0, st:32'h0000_0000, dest:5'd12, s1:5'd31, s2:5'd0};
    localparam in_t V3 = '{valid:1'b1, wb:1'b0, mr:1'b0, mw:1'b1, br:1'b1, imm:1'b0,
                           cmd:4'hA, pc:32'h0000_0300, v1:32'hAAAA_5555,
                           v2:32'h0000_0040, st:32'hCAFE_F00D, dest:5'd7, s1:5'd8, s2:5'd9};
    localparam in_t VINV = '{valid:1'b0, wb:1'b1, mr:1'b1, mw:1'b1, br:1'b1, imm:1'b1,
                           cmd:4'hF, pc:32'h0000_0400, v1:32'h0BAD_0BAD,
                           v2:32'h0000_0077, st:32'h0000_0088, dest:5'd17, s1:5'd18, s2:5'd19};
    // VINV as EXE must show it: control/indices cleared, data carried
    localparam in_t VINV_EXP = '{valid:1'b0, wb:1'b0, mr:1'b0, mw:1'b0, br:1'b0, imm:1'b0,
                           cmd:4'h0, pc:32'h0000_0400, v1:32'h0BAD_0BAD,
                           v2:32'h0000_0077, st:32'h0000_0088, dest:5'd0, s1:5'd0, s2:5'd0};

    task automatic push(input string name, input exp_t e);
        q_exp.push_back(e);
        q_name.push_back(name);
    endtask

    // Drive one cycle's inputs at the falling edge; expect e after the next rising edge.
    task automatic step(input string name, input logic fl, input logic fr, input logic bu,
                        input in_t v, input exp_t e);
        @(negedge clk);
        flush = fl; freeze = fr; bubble = bu; id = v;
        push(name, e);
        cur = e;
    endtask

    initial begin : monitor
        exp_t  act, e;
        string nm;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (q_exp.size() > 0) begin
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                act = '{o:'{valid:e_valid, wb:e_wb, mr:e_mr, mw:e_mw, br:e_br, imm:e_imm,
                            cmd:e_cmd, pc:e_pc, v1:e_v1, v2:e_v2, st:e_st,
                            dest:e_dest, s1:e_s1, s2:e_s2},
                        bc:bcnt, fc:fcnt, bc4:bcnt4, fc4:fcnt4};
                n_cmp++;
                if (act !== e) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", nm, act, e);
                end
            end
        end
    end

    initial begin : stim
        exp_t e;
        int   waited;
        cur = '0;

        step("reset_hold", 0, 0, 0, V3, '0);
        @(negedge clk); rst_n = 1'b1; id = V1; push("load_v1", '{o:V1, bc:0, fc:0, bc4:0, fc4:0});

        // Asynchronous reset mid-cycle with nonzero outputs
        @(negedge clk);
        id = V2; freeze = 1'b1;
        #2;
        push("async_reset", '0);
        rst_n = 1'b0;
        step("reset_during_freeze", 0, 1, 0, V2, '0);
        @(negedge clk);
        rst_n = 1'b1; freeze = 1'b0; id = V1;
        push("first_load_after_reset", '{o:V1, bc:0, fc:0, bc4:0, fc4:0});
        cur = '{o:V1, bc:0, fc:0, bc4:0, fc4:0};

        for (int i = 0; i < 3; i++)
            step("freeze_hold", 0, 1, 0, (i == 1) ? V3 : V2, cur);

        step("load_v2", 0, 0, 0, V2, '{o:V2, bc:0, fc:0, bc4:0, fc4:0});
        step("bubble_store", 0, 0, 1, V3, '{o:'0, bc:1, fc:0, bc4:1, fc4:0});
        step("load_invalid", 0, 0, 0, VINV, '{o:VINV_EXP, bc:1, fc:0, bc4:1, fc4:0});
        step("flush_freeze_bubble", 1, 1, 1, V1, '{o:'0, bc:1, fc:1, bc4:1, fc4:1});
        step("load_v1_again", 0, 0, 0, V1, '{o:V1, bc:1, fc:1, bc4:1, fc4:1});
        step("flush_over_freeze", 1, 1, 0, V2, '{o:'0, bc:1, fc:2, bc4:1, fc4:2});
        step("load_v3", 0, 0, 0, V3, '{o:V3, bc:1, fc:2, bc4:1, fc4:2});
        step("freeze_bubble_holds", 0, 1, 1, V1, '{o:V3, bc:1, fc:2, bc4:1, fc4:2});
        step("flush_alone", 1, 0, 0, V1, '{o:'0, bc:1, fc:3, bc4:1, fc4:3});

        // 20 bubbles: 16-bit counter reaches 21, 4-bit counter pins at 15
        for (int i = 1; i <= 20; i++) begin
            e = '{o:'0, bc:16'(1 + i), fc:3, bc4:4'((1 + i > 15) ? 15 : 1 + i), fc4:3};
            step("bubble_saturate", 0, 0, 1, V2, e);
        end
        step("sat_holds_on_load", 0, 0, 0, V2, '{o:V2, bc:21, fc:3, bc4:15, fc4:3});

        @(negedge clk);
        flush = 0; freeze = 0; bubble = 0;
        waited = 0;
        while (q_exp.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (q_exp.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0 pending", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
